reg_file: RTL and testbench

Parametrised general-purpose register file for the RISC-like CPU datapath. Replaces the fixed 16×8 register bank with configurable width, depth and read-port count. Adds an optional hardwired-zero register, write-to-read bypass, and a sequenced bulk-clear engine. Sits between decode (read addresses) and writeback (write port).

---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/rf_clear_seq.sv | 71 +++++++
 rtl/reg_file.sv | 79 +++++++
 tb/tb_reg_file.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and constants for the parametrised register file.
//   rf_state_t  - bulk-clear sequencer state
//   *_DEF       - default parameter values
//   slice_lsb() - bit offset of port k in a packed multi-port bus
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 4;
  localparam int N_RD_DEF     = 2;
  localparam int ZERO_REG_DEF = 0;
  localparam int BYPASS_DEF   = 1;

  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: bulk-clear sequencer. Walks idx 0..DEPTH-1, one entry per cycle.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   clr_req              - start a sweep (ignored while sweeping)
//   clr_busy, clr_done   - sweep in progress / last sweep cycle
//   wr_rdy               - write port available (low while sweeping)
//   swp_we, swp_addr     - sweep write-enable and entry being zeroed
// All outputs decode from state/idx only, so nothing is combinational from inputs.
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_rdy,
  output logic              swp_we,
  output logic [ADDR_W-1:0] swp_addr
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        // clr_req is deliberately not looked at here: a sweep never restarts
        if (idx == LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign clr_busy = (state == CLEAR);
  assign clr_done = clr_busy && (idx == LAST);
  assign wr_rdy   = !clr_busy;
  assign swp_we   = clr_busy;
  assign swp_addr = idx;

endmodule

// File: rtl/reg_file.sv
// reg_file: parametrised GPR file, 1 write port, N_RD combinational read ports.
// Ports:
//   clk, rst_n                - clock, async active-low reset (zeroes all entries)
//   we, dst, data, wr_rdy     - write port; accepted when we && wr_rdy
//   src, rdata                - packed read addresses / data, port k at slot k
//   clr_req, clr_busy, clr_done - bulk clear control/status
// Options: ZERO_REG hardwires r0 to 0; BYPASS forwards accepted write data to
// matching read ports in the same cycle.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_RD     = N_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        dst,
  input  logic [DATA_W-1:0]        data,
  output logic                     wr_rdy,
  input  logic [N_RD*ADDR_W-1:0]   src,
  output logic [N_RD*DATA_W-1:0]   rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic                         swp_we;
  logic [ADDR_W-1:0]            swp_addr;
  logic                         wr_acc, wr_eff;

  rf_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_rdy   (wr_rdy),
    .swp_we   (swp_we),
    .swp_addr (swp_addr)
  );

  assign wr_acc = we && wr_rdy;
  // accepted writes to r0 are swallowed when r0 is hardwired
  assign wr_eff = wr_acc && !((ZERO_REG != 0) && (dst == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (swp_we) begin
      regs[swp_addr] <= '0;
    end else if (wr_eff) begin
      regs[dst] <= data;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rd;

    assign a = src[slice_lsb(k, ADDR_W) +: ADDR_W];

    // priority: zero register > bypass > array
    always_comb begin
      rd = regs[a];
      if ((BYPASS != 0) && wr_acc && (dst == a)) rd = data;
      if ((ZERO_REG != 0) && (a == '0))          rd = '0;
    end

    assign rdata[slice_lsb(k, DATA_W) +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_reg_file.sv
`timescale 1ns/100ps
module tb_reg_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u0: defaults (BYPASS=1, ZERO_REG=0); u1: ZERO_REG=1, BYPASS=0; share inputs
  logic        we, clr_req;
  logic [3:0]  dst;
  logic [7:0]  data;
  logic [7:0]  src;
  logic [15:0] rd0, rd1;
  logic        wr_rdy0, busy0, done0, wr_rdy1, busy1, done1;

  // u2: DATA_W=16, ADDR_W=5, N_RD=3
  logic        we2, clr_req2;
  logic [4:0]  dst2;
  logic [15:0] data2;
  logic [14:0] src2;
  logic [47:0] rd2;
  logic        wr_rdy2, busy2, done2;

  reg_file u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .dst(dst), .data(data), .wr_rdy(wr_rdy0),
    .src(src), .rdata(rd0), .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0)
  );

  reg_file #(.ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we), .dst(dst), .data(data), .wr_rdy(wr_rdy1),
    .src(src), .rdata(rd1), .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1)
  );

  reg_file #(.DATA_W(16), .ADDR_W(5), .N_RD(3)) u2 (
    .clk(clk), .rst_n(rst_n), .we(we2), .dst(dst2), .data(data2), .wr_rdy(wr_rdy2),
    .src(src2), .rdata(rd2), .clr_req(clr_req2), .clr_busy(busy2), .clr_done(done2)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       we;
    logic [3:0] dst;
    logic [7:0] data;
    logic [3:0] s0, s1;
    logic [7:0] e0a, e0b, e1a, e1b;  // u0 port0/1, u1 port0/1
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, nd;
    vt[0] = '{1'b1, 4'd5, 8'h3C, 4'd5, 4'd0, 8'h3C, 8'h00, 8'h00, 8'h00};
    vt[1] = '{1'b0, 4'd0, 8'h00, 4'd5, 4'd0, 8'h3C, 8'h00, 8'h3C, 8'h00};
    vt[2] = '{1'b1, 4'd0, 8'hFF, 4'd0, 4'd0, 8'hFF, 8'hFF, 8'h00, 8'h00};
    vt[3] = '{1'b0, 4'd0, 8'h00, 4'd0, 4'd5, 8'hFF, 8'h3C, 8'h00, 8'h3C};
    vt[4] = '{1'b1, 4'd5, 8'h44, 4'd5, 4'd5, 8'h44, 8'h44, 8'h3C, 8'h3C};
    vt[5] = '{1'b0, 4'd0, 8'h00, 4'd5, 4'd0, 8'h44, 8'hFF, 8'h44, 8'h00};
    vt[6] = '{1'b1, 4'd9, 8'h5A, 4'd9, 4'd5, 8'h5A, 8'h44, 8'h00, 8'h44};
    vt[7] = '{1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 8'h5A, 8'h5A, 8'h5A, 8'h5A};

    we = 0; clr_req = 0; dst = 0; data = 0; src = 0;
    we2 = 0; clr_req2 = 0; dst2 = 0; data2 = 0; src2 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_wr_rdy0", wr_rdy0, 1'b1);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_done0", done0, 1'b0);
    chk("rst_rd0", rd0, 16'h0000);
    chk("rst_wr_rdy2", wr_rdy2, 1'b1);
    chk("rst_rd2", rd2, 48'h0);
    cyc();

    // table-driven write/read/bypass/zero-reg vectors
    for (int i = 0; i < 8; i++) begin
      we = vt[i].we; dst = vt[i].dst; data = vt[i].data; src = {vt[i].s1, vt[i].s0};
      #1;
      chk($sformatf("v%0d_u0_p0", i), rd0[7:0],  vt[i].e0a);
      chk($sformatf("v%0d_u0_p1", i), rd0[15:8], vt[i].e0b);
      chk($sformatf("v%0d_u1_p0", i), rd1[7:0],  vt[i].e1a);
      chk($sformatf("v%0d_u1_p1", i), rd1[15:8], vt[i].e1b);
      cyc();
    end
    we = 0;

    // async reset mid-cycle clears everything at once
    for (int i = 0; i < 16; i++) begin
      we = 1; dst = 4'(i); data = 8'hA5;
      cyc();
    end
    we = 0; src = {4'd0, 4'd11};
    #1 chk("pre_rst_r11", rd0[7:0], 8'hA5);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      src[3:0] = 4'(i);
      #0.3;
      chk($sformatf("rst_r%0d", i), rd0[7:0], 8'h00);
    end
    chk("rst_mid_wr_rdy", wr_rdy0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // clear sweep: clr_req sampled at edge N
    for (int i = 0; i < 16; i++) begin
      we = 1; dst = 4'(i); data = 8'h10 + 8'(i);
      cyc();
    end
    we = 0; clr_req = 1; src = {4'd3, 4'd7};
    #1;
    chk("clrN_busy", busy0, 1'b0);
    chk("clrN_r7", rd0[7:0], 8'h17);
    cyc();
    clr_req = 0;
    for (int k = 1; k <= 17; k++) begin
      clr_req = (k == 4);
      we = (k == 5); dst = 4'd3; data = 8'h99;
      #1;
      chk($sformatf("clr%0d_busy", k), busy0, (k <= 16));
      chk($sformatf("clr%0d_done", k), done0, (k == 16));
      chk($sformatf("clr%0d_wr_rdy", k), wr_rdy0, (k > 16));
      if (k == 8) chk("clr8_r7", rd0[7:0], 8'h17);
      if (k >= 9) chk($sformatf("clr%0d_r7", k), rd0[7:0], 8'h00);
      if (k == 5) chk("clr5_r3_nobypass", rd0[15:8], 8'h00);
      cyc();
    end
    we = 0; clr_req = 0;
    src = {4'd3, 4'd15};
    #1;
    chk("post_clr_r3", rd0[15:8], 8'h00);
    chk("post_clr_r15", rd0[7:0], 8'h00);
    cyc();

    // reset in the middle of a sweep
    for (int i = 14; i < 16; i++) begin
      we = 1; dst = 4'(i); data = 8'h10 + 8'(i);
      cyc();
    end
    we = 0; clr_req = 1;
    cyc();
    clr_req = 0;
    repeat (5) cyc();
    src = {4'd15, 4'd14};
    #1;
    chk("msw_busy_pre", busy0, 1'b1);
    chk("msw_r14_pre", rd0[7:0], 8'h1E);
    rst_n = 1'b0;
    #1;
    chk("msw_busy", busy0, 1'b0);
    chk("msw_done", done0, 1'b0);
    chk("msw_wr_rdy", wr_rdy0, 1'b1);
    chk("msw_rd", rd0, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("msw_done_rel", done0, 1'b0);
    cyc();
    clr_req = 1;
    cyc();
    clr_req = 0;
    nb = 0; nd = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (busy0) nb++;
      if (done0) nd++;
      cyc();
    end
    chk("resweep_busy_cycles", nb, 16);
    chk("resweep_done_pulses", nd, 1);

    // wide instance: 16-bit, 32 entries, 3 ports
    we2 = 1; dst2 = 5'd31; data2 = 16'hBEEF; src2 = {5'd31, 5'd17, 5'd31};
    #1 chk("w_byp_31", rd2, {16'hBEEF, 16'h0000, 16'hBEEF});
    cyc();
    dst2 = 5'd17; data2 = 16'h1234;
    #1 chk("w_byp_17", rd2, {16'hBEEF, 16'h1234, 16'hBEEF});
    cyc();
    we2 = 0; src2 = {5'd17, 5'd31, 5'd17};
    #1 chk("w_rd_mix", rd2, {16'h1234, 16'hBEEF, 16'h1234});
    cyc();
    clr_req2 = 1;
    cyc();
    clr_req2 = 0;
    nb = 0; nd = 0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (busy2) nb++;
      if (done2) nd++;
      cyc();
    end
    chk("w_busy_cycles", nb, 32);
    chk("w_done_pulses", nd, 1);
    #1 chk("w_post_clr", rd2, 48'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
